sseg_scan_ctrl: RTL and testbench
=================================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed digits (legal range 2..16).
REQ-002 Parameter DIV_W, default 18, digit dwell = 2^DIV_W enabled cycles (legal minimum 4).
REQ-003 Parameter BLINK_W, default 6, blink half-period = 2^(BLINK_W-1) frames.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  scan advance enable; when low, divider, digit index and blink counter hold.
REQ-007 load  in  1  capture request for the display inputs below into the shadow register.
REQ-008 hex_mode  in  1  1: low nibble of each slot is hex-decoded; 0: slot is raw active-low segments {g,f,e,d,c,b,a}, a = bit 0.
REQ-009 digit_data  in  7*N_DIG  slot k = bits [7k+6:7k]; digit 0 is rightmost.
REQ-010 dp_in / blank_in / blink_in  in  N_DIG each  per-digit decimal point on, force-dark, blink enable.
REQ-011 bright  in  4  brightness level 0..15.
REQ-012 sseg  out  7  active-low segments. dp  out  1  active-low decimal point.
REQ-013 an  out  N_DIG  active-low anodes, at most one bit low.
REQ-014 frame_start  out  1  one-cycle pulse when digit index wraps N_DIG-1 -> 0.
REQ-015 load_ack  out  1  one-cycle pulse when shadow is promoted to active.

Function
REQ-016 Divider (DIV_W bits) increments each cycle en=1 and wraps from all-ones to 0.
REQ-017 On divider wrap, digit index increments; from N_DIG-1 it goes to 0 (non-power-of-two N_DIG supported); frame_start asserts in that same cycle.
REQ-018 load=1 captures digit_data, dp_in, blank_in, blink_in, hex_mode, bright into shadow and sets pending; load while pending overwrites shadow.
REQ-019 On a frame_start cycle with pending=1, active <= shadow, pending <= 0, load_ack = 1; active never changes at any other time (tear-free).
REQ-020 load coincident with a promoting frame_start: the older shadow content is promoted, the new capture stays pending for the next frame.
REQ-021 Hex decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-022 Digit lit iff active blank bit = 0, AND divider[DIV_W-1:DIV_W-4] <= active bright (duty (bright+1)/16), AND NOT (blink bit = 1 and blink phase = 1).
REQ-023 Blink counter (BLINK_W bits) increments on each frame_start; blink phase = its MSB.
REQ-024 Lit digit: an bit for current index low, sseg = decoded/raw segments, dp = NOT dp bit; dark digit: an all ones, sseg = 7F, dp = 1.
REQ-025 sseg, dp, an are registered: they reflect divider/index/active state of the previous cycle (one-cycle latency); frame_start and load_ack are combinational from the same-cycle state.
REQ-026 en=0: outputs keep displaying the held digit at the held PWM position; load/promotion logic still runs but no frame_start occurs, so promotion waits.

Reset
REQ-027 rst=0 immediately forces: divider 0, index 0, blink counter 0, pending 0, shadow and active data 0, active blank all ones, active bright 0, an all ones, sseg 7F, dp 1, frame_start 0, load_ack 0.
REQ-028 After rst rises, display stays dark until the first load is promoted; reset mid-frame discards any pending load.

Verification (bench uses N_DIG=4, DIV_W=4, BLINK_W=2 unless noted)
REQ-029 Scan: load hex_mode=1 digits 3,2,1,0 = 1,2,3,4, bright=15, blanks 0 -> load_ack at first frame_start; an cycles E,D,B,7 each 16 cycles, sseg 19,30,24,79 respectively.
REQ-030 Non-power-of-two: N_DIG=3 -> an sequence 6,5,3,6..., frame_start every 48 cycles, index never reaches 3.
REQ-031 PWM: bright=3 -> each digit's an bit low exactly 4 of its 16 dwell cycles (divider top nibble 0..3); bright=0 -> 1 cycle.
REQ-032 Tear-free/blink: load new data mid-frame -> old digits displayed until frame_start, then new; blink_in=0001 -> digit 0 dark on frames 2-3, lit on frames 0-1 of every 4.
REQ-033 Simultaneous: load A then load B on a frame_start cycle -> A shown next frame, B after following frame_start, two load_ack pulses.
REQ-034 Reset mid-operation: assert rst during digit 2 with load pending -> outputs dark same cycle; after release no load_ack until a new load.

Source files
------------

// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - display bus between a host and the seven-segment scan controller
// Purpose: bundles the display request inputs and the scanned outputs of sseg_scan_ctrl.
// Signals (host -> controller): en, load, hex_mode, digit_data, dp_in, blank_in, blink_in, bright
// Signals (controller -> host): sseg, dp, an, frame_start, load_ack
// Modports: master = host side, slave = controller side.
interface sseg_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic               en;
  logic               load;
  logic               hex_mode;
  logic [7*N_DIG-1:0] digit_data;
  logic [N_DIG-1:0]   dp_in;
  logic [N_DIG-1:0]   blank_in;
  logic [N_DIG-1:0]   blink_in;
  logic [3:0]         bright;
  logic [6:0]         sseg;
  logic               dp;
  logic [N_DIG-1:0]   an;
  logic               frame_start;
  logic               load_ack;

  modport master (
    output en, load, hex_mode, digit_data, dp_in, blank_in, blink_in, bright,
    input  sseg, dp, an, frame_start, load_ack
  );

  modport slave (
    input  en, load, hex_mode, digit_data, dp_in, blank_in, blink_in, bright,
    output sseg, dp, an, frame_start, load_ack
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed seven-segment scan controller with tear-free shadow load
// Purpose: scans N_DIG active-low digits with a 2^DIV_W cycle dwell, 16-level PWM brightness,
//          per-digit blank/blink/decimal point, and a shadow register promoted only at frame wrap.
// Ports:
//   clk  - single clock, all state on its rising edge
//   rst  - asynchronous active-low reset
//   bus  - sseg_scan_ctrl_if slave modport (display inputs, segment/anode outputs, pulses)
module sseg_scan_ctrl #(
  parameter int N_DIG   = 4,
  parameter int DIV_W   = 18,
  parameter int BLINK_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  sseg_scan_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(N_DIG);

  typedef struct packed {
    logic [7*N_DIG-1:0] data;
    logic [N_DIG-1:0]   dp;
    logic [N_DIG-1:0]   blank;
    logic [N_DIG-1:0]   blink;
    logic               hex;
    logic [3:0]         bright;
  } disp_t;

  // Out of reset every digit is blanked, so the display stays dark until a load is promoted.
  localparam disp_t ACTIVE_RST = '{data: '0, dp: '0, blank: '1, blink: '0, hex: 1'b0, bright: 4'd0};

  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               pend_q, pend_d;
  disp_t              shadow_q, shadow_d;
  disp_t              active_q, active_d;
  logic [6:0]         sseg_q, sseg_d;
  logic               dp_q, dp_d;
  logic [N_DIG-1:0]   an_q, an_d;

  logic       div_wrap, frame_start, promote;
  disp_t      capture;
  logic [6:0] slot, seg;
  logic       cur_dp, cur_blank, cur_blink, lit;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_comb begin : ctrl
    div_wrap    = bus.en && (&div_q);
    frame_start = div_wrap && (idx_q == IDX_W'(N_DIG - 1));
    promote     = frame_start && pend_q;
  end

  always_comb begin : next_state
    capture.data   = bus.digit_data;
    capture.dp     = bus.dp_in;
    capture.blank  = bus.blank_in;
    capture.blink  = bus.blink_in;
    capture.hex    = bus.hex_mode;
    capture.bright = bus.bright;

    div_d = bus.en ? div_q + DIV_W'(1) : div_q;
    idx_d = idx_q;
    // Explicit wrap at N_DIG-1 so non-power-of-two digit counts never visit unused indices.
    if (div_wrap) begin
      idx_d = frame_start ? '0 : idx_q + IDX_W'(1);
    end
    blink_d = frame_start ? blink_q + BLINK_W'(1) : blink_q;

    // Promotion uses the shadow as it was before this cycle's capture, so a load landing on
    // the promoting edge stays pending for the following frame.
    active_d = promote ? shadow_q : active_q;
    shadow_d = bus.load ? capture : shadow_q;
    pend_d   = bus.load || (pend_q && !promote);
  end

  always_comb begin : display
    slot      = 7'h7F;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        slot      = active_q.data[7*k +: 7];
        cur_dp    = active_q.dp[k];
        cur_blank = active_q.blank[k];
        cur_blink = active_q.blink[k];
      end
    end
    seg = active_q.hex ? hex_decode(slot[3:0]) : slot;
    // PWM compares the top divider nibble against brightness: duty of (bright+1)/16 per dwell.
    lit = !cur_blank
       && (div_q[DIV_W-1 -: 4] <= active_q.bright)
       && !(cur_blink && blink_q[BLINK_W-1]);
    sseg_d = lit ? seg : 7'h7F;
    dp_d   = lit ? !cur_dp : 1'b1;
    an_d   = lit ? ~(N_DIG'(1) << idx_q) : '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= ACTIVE_RST;
      sseg_q   <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= '1;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      sseg_q   <= sseg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign bus.sseg        = sseg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start;
  assign bus.load_ack    = promote;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BW    = 2;
  localparam int DWELL = 1 << DW;
  localparam int FRAME = DWELL * N;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  always #5 clk = ~clk;

  sseg_scan_ctrl_if #(.N_DIG(4)) bus ();
  sseg_scan_ctrl_if #(.N_DIG(3)) bus3 ();

  sseg_scan_ctrl #(.N_DIG(4), .DIV_W(DW), .BLINK_W(BW)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  sseg_scan_ctrl #(.N_DIG(3), .DIV_W(DW), .BLINK_W(BW)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- reference model: time-based, counts enabled cycles since reset --------
  typedef struct packed {
    logic [27:0] data;
    logic [3:0]  dp, blank, blink;
    logic        hex;
    logic [3:0]  bright;
  } disp_t;

  int         t = 0;
  bit         pend = 0;
  disp_t      sh = '0;
  disp_t      act = '{data: '0, dp: '0, blank: 4'hF, blink: '0, hex: 1'b0, bright: 4'd0};
  logic [6:0] e_sseg = 7'h7F;
  logic       e_dp = 1'b1;
  logic [3:0] e_an = 4'hF;
  int         m_d, m_pos, m_frame;
  bit         m_lit;
  logic [6:0] m_raw;

  function automatic bit m_fs();
    return bus.en && ((t % FRAME) == FRAME - 1);
  endfunction

  task automatic model_step();
    if (!rst) begin
      t = 0; pend = 0; sh = '0;
      act = '0; act.blank = 4'hF;
      e_sseg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      m_d     = (t / DWELL) % N;
      m_pos   = t % DWELL;
      m_frame = t / FRAME;
      m_lit   = !act.blank[m_d] && ((m_pos >> (DW - 4)) <= int'(act.bright))
             && !(act.blink[m_d] && (((m_frame >> (BW - 1)) % 2) == 1));
      m_raw   = act.data[7*m_d +: 7];
      if (m_lit) begin
        e_sseg = act.hex ? HEX[m_raw[3:0]] : m_raw;
        e_dp   = !act.dp[m_d];
        e_an   = 4'hF & ~(4'h1 << m_d);
      end else begin
        e_sseg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end
      if (m_fs() && pend) begin act = sh; pend = 0; end
      if (bus.load) begin
        sh.data = bus.digit_data; sh.dp = bus.dp_in; sh.blank = bus.blank_in;
        sh.blink = bus.blink_in; sh.hex = bus.hex_mode; sh.bright = bus.bright;
        pend = 1;
      end
      if (bus.en) t++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("sseg", {25'd0, bus.sseg}, {25'd0, e_sseg});
    chk("dp", {31'd0, bus.dp}, {31'd0, e_dp});
    chk("an", {28'd0, bus.an}, {28'd0, e_an});
    chk("frame_start", {31'd0, bus.frame_start}, {31'd0, m_fs()});
    chk("load_ack", {31'd0, bus.load_ack}, {31'd0, m_fs() && pend});
  end

  // ---------------- helpers ----------------
  int         cnt [N];
  logic [6:0] seen [N];

  task automatic clr();
    for (int k = 0; k < N; k++) begin cnt[k] = 0; seen[k] = 7'h7F; end
  endtask

  task automatic scan_frame();
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (bus.an[k] === 1'b0) begin cnt[k]++; seen[k] = bus.sseg; end
      end
    end
  endtask

  task automatic load_disp(input logic hx, input logic [27:0] data, input logic [3:0] dpv,
                           input logic [3:0] blk, input logic [3:0] bln, input logic [3:0] br);
    bus.hex_mode = hx; bus.digit_data = data; bus.dp_in = dpv;
    bus.blank_in = blk; bus.blink_in = bln; bus.bright = br;
    bus.load = 1'b1;
    @(posedge clk); #2;
    bus.load = 1'b0;
  endtask

  task automatic wait_ack(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic       hex;
    logic [6:0] slot;
    logic [6:0] exp;
  } vec_t;
  vec_t vt [19];

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int acks;
    vt[0]  = '{1'b1, 7'h00, 7'h40}; vt[1]  = '{1'b1, 7'h01, 7'h79};
    vt[2]  = '{1'b1, 7'h02, 7'h24}; vt[3]  = '{1'b1, 7'h03, 7'h30};
    vt[4]  = '{1'b1, 7'h04, 7'h19}; vt[5]  = '{1'b1, 7'h05, 7'h12};
    vt[6]  = '{1'b1, 7'h06, 7'h02}; vt[7]  = '{1'b1, 7'h07, 7'h78};
    vt[8]  = '{1'b1, 7'h08, 7'h00}; vt[9]  = '{1'b1, 7'h09, 7'h10};
    vt[10] = '{1'b1, 7'h0A, 7'h08}; vt[11] = '{1'b1, 7'h0B, 7'h03};
    vt[12] = '{1'b1, 7'h0C, 7'h46}; vt[13] = '{1'b1, 7'h0D, 7'h21};
    vt[14] = '{1'b1, 7'h0E, 7'h06}; vt[15] = '{1'b1, 7'h0F, 7'h0E};
    vt[16] = '{1'b1, 7'h7A, 7'h08}; vt[17] = '{1'b0, 7'h55, 7'h55};
    vt[18] = '{1'b0, 7'h3C, 7'h3C};

    bus.en = 0; bus.load = 0; bus.hex_mode = 0; bus.digit_data = '0;
    bus.dp_in = '0; bus.blank_in = '0; bus.blink_in = '0; bus.bright = '0;
    #1 rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_an", {28'd0, bus.an}, 32'hF);
    chk("rst_sseg", {25'd0, bus.sseg}, 32'h7F);
    chk("rst_dp", {31'd0, bus.dp}, 32'h1);
    chk("rst_frame_start", {31'd0, bus.frame_start}, 32'h0);
    chk("rst_load_ack", {31'd0, bus.load_ack}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1; bus.en = 1'b1;

    // Basic scan: digits 3..0 = 1,2,3,4
    load_disp(1'b1, {7'd1, 7'd2, 7'd3, 7'd4}, 4'h0, 4'h0, 4'h0, 4'hF);
    wait_ack(200, ok);
    chk("scan_ack", {31'd0, ok}, 32'h1);
    chk("scan_ack_on_frame", {31'd0, bus.frame_start}, 32'h1);
    @(negedge clk);
    clr(); scan_frame();
    for (int k = 0; k < N; k++) chk($sformatf("scan_dwell_d%0d", k), cnt[k], 16);
    chk("scan_seg_d0", {25'd0, seen[0]}, 32'h19);
    chk("scan_seg_d1", {25'd0, seen[1]}, 32'h30);
    chk("scan_seg_d2", {25'd0, seen[2]}, 32'h24);
    chk("scan_seg_d3", {25'd0, seen[3]}, 32'h79);

    // Decode table
    for (int i = 0; i < 19; i++) begin
      load_disp(vt[i].hex, {4{vt[i].slot}}, 4'h0, 4'h0, 4'h0, 4'hF);
      wait_ack(200, ok);
      chk($sformatf("dec_ack_%0d", i), {31'd0, ok}, 32'h1);
      @(negedge clk); @(negedge clk);
      chk($sformatf("dec_an_%0d", i), {28'd0, bus.an}, 32'hE);
      chk($sformatf("dec_seg_%0d", i), {25'd0, bus.sseg}, {25'd0, vt[i].exp});
    end

    // PWM duty
    load_disp(1'b1, {4{7'h08}}, 4'h5, 4'h0, 4'h0, 4'd3);
    wait_ack(200, ok); chk("pwm3_ack", {31'd0, ok}, 32'h1);
    @(negedge clk); clr(); scan_frame();
    for (int k = 0; k < N; k++) chk($sformatf("pwm3_d%0d", k), cnt[k], 4);
    load_disp(1'b1, {4{7'h08}}, 4'hA, 4'h0, 4'h0, 4'd0);
    wait_ack(200, ok); chk("pwm0_ack", {31'd0, ok}, 32'h1);
    @(negedge clk); clr(); scan_frame();
    for (int k = 0; k < N; k++) chk($sformatf("pwm0_d%0d", k), cnt[k], 1);

    // Blink on digit 0: dark for two of every four frames
    load_disp(1'b1, {4{7'h03}}, 4'h0, 4'h0, 4'b0001, 4'hF);
    wait_ack(200, ok); chk("blink_ack", {31'd0, ok}, 32'h1);
    @(negedge clk); clr();
    repeat (4) scan_frame();
    chk("blink_d0", cnt[0], 32);
    chk("blink_d1", cnt[1], 64);

    // Tear-free: mid-frame load waits for the frame boundary
    load_disp(1'b1, {4{7'h08}}, 4'h0, 4'h0, 4'h0, 4'hF);
    wait_ack(200, ok); chk("tear_ack1", {31'd0, ok}, 32'h1);
    repeat (20) @(negedge clk);
    load_disp(1'b1, {4{7'h01}}, 4'h0, 4'h0, 4'h0, 4'hF);
    wait_ack(200, ok); chk("tear_ack2", {31'd0, ok}, 32'h1);

    // Load landing on the promoting frame_start
    repeat (10) @(negedge clk);
    load_disp(1'b1, {4{7'h0A}}, 4'h0, 4'h0, 4'h0, 4'hF);
    wait_ack(200, ok); chk("simul_ackA", {31'd0, ok}, 32'h1);
    bus.digit_data = {4{7'h0B}}; bus.load = 1'b1;
    @(posedge clk); #2 bus.load = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("simul_showA", {25'd0, bus.sseg}, 32'h08);
    wait_ack(200, ok); chk("simul_ackB", {31'd0, ok}, 32'h1);
    @(negedge clk); @(negedge clk);
    chk("simul_showB", {25'd0, bus.sseg}, 32'h03);

    // Reset during digit 2 with a load pending
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.an === 4'hB) begin ok = 1; break; end
    end
    chk("mrst_find_d2", {31'd0, ok}, 32'h1);
    bus.digit_data = {4{7'h06}}; bus.load = 1'b1;
    @(posedge clk); #2 bus.load = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mrst_an", {28'd0, bus.an}, 32'hF);
    chk("mrst_sseg", {25'd0, bus.sseg}, 32'h7F);
    chk("mrst_dp", {31'd0, bus.dp}, 32'h1);
    chk("mrst_load_ack", {31'd0, bus.load_ack}, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.load_ack === 1'b1) acks++;
    end
    chk("mrst_no_ack", acks, 0);
    load_disp(1'b1, {4{7'h02}}, 4'h0, 4'h0, 4'h0, 4'hF);
    wait_ack(200, ok); chk("mrst_new_ack", {31'd0, ok}, 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.en         = ($urandom_range(7) != 0);
      bus.load       = ($urandom_range(39) == 0);
      bus.hex_mode   = 1'($urandom_range(1));
      bus.digit_data = 28'($urandom);
      bus.dp_in      = 4'($urandom);
      bus.blank_in   = 4'($urandom) & 4'($urandom);
      bus.blink_in   = 4'($urandom);
      bus.bright     = 4'($urandom);
      @(posedge clk); #2;
    end
    bus.load = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // ---------------- three-digit instance: non-power-of-two wrap ----------------
  initial begin
    bit ok;
    logic [2:0] exp_an;
    bus3.en = 0; bus3.load = 0; bus3.hex_mode = 1; bus3.digit_data = {7'd3, 7'd2, 7'd1};
    bus3.dp_in = '0; bus3.blank_in = '0; bus3.blink_in = '0; bus3.bright = 4'hF;
    #1 rst3 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst3 = 1'b1; bus3.en = 1'b1; bus3.load = 1'b1;
    @(posedge clk); #2 bus3.load = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus3.frame_start === 1'b1) begin ok = 1; break; end
    end
    chk("nd3_first_frame", {31'd0, ok}, 32'h1);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      chk("nd3_frame_start", {31'd0, bus3.frame_start}, {31'd0, ((k - 1) % 48) == 47});
      if (k >= 2) begin
        exp_an = 3'b111 & ~(3'b001 << (((k - 2) / 16) % 3));
        chk("nd3_an", {29'd0, bus3.an}, {29'd0, exp_an});
      end
    end
  end
endmodule
